trace_buffer: RTL

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/trace_buffer.sv
// trace_buffer: captures {PC, instr, destRegData} into a first-word-fall-through
// FIFO from a start pulse until the program counter reaches stop_pc.
// Optional macro TRACE_DEDUP_EN suppresses repeated pushes of the same PC
// (halted or self-looping processor).
module trace_buffer #(
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [18:0]              PC,
   input  logic [20:0]              instr,
   input  logic [20:0]              destRegData,
   input  logic                     start,
   input  logic [18:0]              stop_pc,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [60:0]              out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               overflow_cnt,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      STOPPED = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  ovf_q, ovf_d;
   logic [60:0] mem_q [DEPTH];

   logic [AW:0] level_w;
   logic        full;
   logic        pop;
   logic        push_req;
   logic        push_ok;
   logic        entering_capture;
   logic        dup;

   assign level_w          = wr_ptr_q - rd_ptr_q;
   assign full             = (level_w == FULL_LEVEL);
   assign out_valid        = (level_w != '0);
   assign pop              = out_valid && out_ready;
   assign entering_capture = (state_q != CAPTURE) && (state_d == CAPTURE);
   assign push_req         = (state_q == CAPTURE) && !dup;
   assign push_ok          = push_req && (!full || pop);

   assign level        = level_w;
   assign overflow_cnt = ovf_q;
   assign state        = state_q;
   assign out_data     = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

`ifdef TRACE_DEDUP_EN
   logic [18:0] last_pc_q, last_pc_d;
   logic        last_vld_q, last_vld_d;

   assign dup = last_vld_q && (PC == last_pc_q);

   // Track the PC of the most recent non-suppressed push; forget it on each new capture
   always_comb begin
      last_pc_d  = last_pc_q;
      last_vld_d = last_vld_q;
      if (entering_capture) begin
         last_vld_d = 1'b0;
      end else if (push_req) begin
         last_pc_d  = PC;
         last_vld_d = 1'b1;
      end
   end

   // Last-PC register with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         last_pc_q  <= '0;
         last_vld_q <= 1'b0;
      end else begin
         last_pc_q  <= last_pc_d;
         last_vld_q <= last_vld_d;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Capture control: start arms capture, reaching stop_pc ends it
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CAPTURE;
         CAPTURE: if (PC == stop_pc) state_d = STOPPED;
         STOPPED: if (start) state_d = CAPTURE;
         default: state_d = IDLE;
      endcase
   end

   // Pointer advance and saturating count of pushes lost to a full FIFO
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_req && full && !pop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
   end

   // Control registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage; contents are don't-care until written, reads are masked when empty
   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {PC, instr, destRegData};
   end

endmodule
